// File: rtl/addsub_accumulator_if.sv
// Bus bundle for addsub_accumulator: operation request, result/flags output
// and the drive/return pair to the external ripple adder/subtractor.
interface addsub_accumulator_if #(
  parameter int WIDTH = 4
);
  // Operation request (upstream)
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand;

  // External adder/subtractor connection
  logic [WIDTH-1:0] addsub_a;
  logic [WIDTH-1:0] addsub_b;
  logic             addsub_cin;
  logic [WIDTH-1:0] addsub_sum;
  logic             addsub_cout;

  // Result and status (downstream)
  logic [WIDTH-1:0] acc;
  logic             flag_c;
  logic             flag_z;
  logic             flag_n;
  logic             flag_v;
  logic             out_valid;
  logic             out_ready;

  // Accumulator side: consumes requests and adder results, produces status
  modport slave (
    input  in_valid, op, operand, addsub_sum, addsub_cout, out_ready,
    output in_ready, addsub_a, addsub_b, addsub_cin,
           acc, flag_c, flag_z, flag_n, flag_v, out_valid
  );

  // Environment side: issues requests, hosts the adder, takes results
  modport master (
    output in_valid, op, operand, addsub_sum, addsub_cout, out_ready,
    input  in_ready, addsub_a, addsub_b, addsub_cin,
           acc, flag_c, flag_z, flag_n, flag_v, out_valid
  );
endinterface

// File: rtl/addsub_accumulator.sv
// Sequencing/result-capture stage around an external combinational
// WIDTH-bit ripple adder/subtractor. One operation per input handshake:
// IDLE accepts, EXEC lets the adder settle and captures its result at the
// closing edge, RESP holds the result and flags until the consumer takes it.
module addsub_accumulator #(
  parameter int WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  addsub_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  // Two's-complement overflow of a +/- b given the adder's effective b input
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic cin, input logic sum_msb);
    return ~(a_msb ^ (b_msb ^ cin)) & (sum_msb ^ a_msb);
  endfunction

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             flag_c_q, flag_c_d;
  logic             flag_z_q, flag_z_d;
  logic             flag_n_q, flag_n_d;
  logic             flag_v_q, flag_v_d;
  logic             in_ready_q;
  logic             out_valid_q;

  // The adder is driven continuously from the stored state, in every state
  assign bus.addsub_a   = acc_q;
  assign bus.addsub_b   = opnd_q;
  assign bus.addsub_cin = (op_q == OP_SUB);

  assign bus.acc       = acc_q;
  assign bus.flag_c    = flag_c_q;
  assign bus.flag_z    = flag_z_q;
  assign bus.flag_n    = flag_n_q;
  assign bus.flag_v    = flag_v_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;

  // Next-state, operand latch and EXEC-only accumulator/flag update
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    flag_c_d = flag_c_q;
    flag_z_d = flag_z_q;
    flag_n_d = flag_n_q;
    flag_v_d = flag_v_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          op_d    = bus.op;
          opnd_d  = bus.operand;
          state_d = ST_EXEC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d = ST_RESP;
        case (op_q)
          OP_ADD, OP_SUB: begin
            acc_d    = bus.addsub_sum;
            flag_c_d = bus.addsub_cout;
            flag_v_d = signed_ovf(acc_q[WIDTH-1], opnd_q[WIDTH-1],
                                  (op_q == OP_SUB), bus.addsub_sum[WIDTH-1]);
          end
          OP_LOAD: begin
            acc_d    = opnd_q;
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
          end
          OP_CLEAR: begin
            acc_d    = {WIDTH{1'b0}};
            flag_c_d = 1'b0;
            flag_v_d = 1'b0;
          end
          default: begin
            acc_d    = acc_q;
            flag_c_d = flag_c_q;
            flag_v_d = flag_v_q;
          end
        endcase
        flag_z_d = (acc_d == {WIDTH{1'b0}});
        flag_n_d = acc_d[WIDTH-1];
      end
      ST_RESP: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs; reset wins over all
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'b00;
      opnd_q      <= {WIDTH{1'b0}};
      acc_q       <= {WIDTH{1'b0}};
      flag_c_q    <= 1'b0;
      flag_z_q    <= 1'b0;
      flag_n_q    <= 1'b0;
      flag_v_q    <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      opnd_q      <= opnd_d;
      acc_q       <= acc_d;
      flag_c_q    <= flag_c_d;
      flag_z_q    <= flag_z_d;
      flag_n_q    <= flag_n_d;
      flag_v_q    <= flag_v_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_RESP);
    end
  end

endmodule

// File: tb/tb_addsub_accumulator.sv
// Directed bench for addsub_accumulator with a behavioural model of the
// external 4-bit ripple adder/subtractor (b inverted and cin added on SUB).
module tb_addsub_accumulator;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_ADD   = 2'b01;
  localparam logic [1:0] OP_SUB   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  addsub_accumulator_if #(.WIDTH(4)) bus ();

  addsub_accumulator #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // External adder/subtractor model
  logic [4:0] add_full;
  assign add_full = {1'b0, bus.addsub_a}
                  + {1'b0, bus.addsub_b ^ {4{bus.addsub_cin}}}
                  + {4'b0000, bus.addsub_cin};
  assign bus.addsub_sum  = add_full[3:0];
  assign bus.addsub_cout = add_full[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {acc, c, z, n, v, out_valid, in_ready}
  function automatic logic [9:0] snap();
    return {bus.acc, bus.flag_c, bus.flag_z, bus.flag_n, bus.flag_v,
            bus.out_valid, bus.in_ready};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op and advance to RESP (no result checking here)
  task automatic issue(input logic [1:0] op, input logic [3:0] operand);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: in_ready=%b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.operand  = operand;
    tick();
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.operand  = 4'b0000;
    tick();
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [9:0] got;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    got = snap();
    checks++;
    if (got !== {4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got %b want 0000_0000_01", got);
    end
    issue(OP_LOAD, 4'b1010);
    got = snap();
    checks++;
    if (got !== {4'b1010, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL load_1010: got %b want 1010_0010_10", got);
    end
    consume();
    got = snap();
    checks++;
    if (got[1:0] !== 2'b01) begin
      errors++;
      $display("FAIL load_consume: out_valid/in_ready got %b want 01", got[1:0]);
    end
  endtask

  task automatic test_addsub();
    logic [1:0] ops [4];
    logic [3:0] opnds [4];
    logic [9:0] exps [4];
    logic [9:0] got;
    ops[0] = OP_ADD; opnds[0] = 4'b0100; exps[0] = {4'b1110, 4'b0010, 2'b10};
    ops[1] = OP_SUB; opnds[1] = 4'b1100; exps[1] = {4'b0010, 4'b1000, 2'b10};
    ops[2] = OP_ADD; opnds[2] = 4'b0111; exps[2] = {4'b1001, 4'b0011, 2'b10};
    ops[3] = OP_SUB; opnds[3] = 4'b1001; exps[3] = {4'b0000, 4'b1100, 2'b10};
    issue(OP_LOAD, 4'b1010);
    consume();
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], opnds[i]);
      got = snap();
      checks++;
      if (got !== exps[i]) begin
        errors++;
        $display("FAIL addsub_step%0d: got %b want %b", i, got, exps[i]);
      end
      consume();
    end
  endtask

  task automatic test_wrap_clear();
    logic [9:0] got;
    issue(OP_LOAD, 4'b1111);
    consume();
    issue(OP_ADD, 4'b0001);
    got = snap();
    checks++;
    if (got !== {4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap_add: got %b want 0000_1100_10", got);
    end
    consume();
    issue(OP_CLEAR, 4'b0110);
    got = snap();
    checks++;
    if (got !== {4'b0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL clear: got %b want 0000_0100_10", got);
    end
    consume();
  endtask

  task automatic test_backpressure();
    logic [9:0] got;
    logic [9:0] hold;
    hold = {4'b0011, 4'b0000, 2'b10};
    issue(OP_ADD, 4'b0011);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0] ? 1'b0 : 1'b1;
      bus.op       = i[1:0];
      bus.operand  = 4'(i * 3 + 5);
      tick();
      got = snap();
      checks++;
      if (got !== hold) begin
        errors++;
        $display("FAIL backpressure_cyc%0d: got %b want %b", i, got, hold);
      end
    end
    bus.in_valid = 1'b0;
    consume();
    got = snap();
    checks++;
    if (got !== {4'b0011, 4'b0000, 2'b01}) begin
      errors++;
      $display("FAIL backpressure_release: got %b want 0011_0000_01", got);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] got;
    for (int pass = 0; pass < 2; pass++) begin
      issue(OP_LOAD, 4'b0100);
      consume();
      if (pass == 0) begin
        bus.in_valid = 1'b1;
        bus.op       = OP_ADD;
        bus.operand  = 4'b0011;
        tick();
        bus.in_valid = 1'b0;
      end else begin
        issue(OP_ADD, 4'b0011);
        got = snap();
        checks++;
        if (got !== {4'b0111, 4'b0000, 2'b10}) begin
          errors++;
          $display("FAIL mid_resp_pre: got %b want 0111_0000_10", got);
        end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      got = snap();
      checks++;
      if (got !== {4'b0000, 4'b0000, 2'b01}) begin
        errors++;
        $display("FAIL reset_mid_pass%0d: got %b want 0000_0000_01", pass, got);
      end
      tick();
      tick();
      got = snap();
      checks++;
      if (got !== {4'b0000, 4'b0000, 2'b01}) begin
        errors++;
        $display("FAIL reset_mid_later_pass%0d: got %b want 0000_0000_01", pass, got);
      end
    end
  endtask

  task automatic test_back_to_back();
    int         n_acc;
    int         last;
    logic [3:0] acc_exp;
    logic       in_exec;
    logic [8:0] adder_got;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_acc   = 0;
    last    = -1;
    acc_exp = 4'b0000;
    in_exec = 1'b0;
    bus.op        = OP_ADD;
    bus.operand   = 4'b0001;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus.in_valid = (n_acc < 4);
      if (in_exec) begin
        adder_got = {bus.addsub_a, bus.addsub_b, bus.addsub_cin};
        checks++;
        if (adder_got !== {acc_exp, 4'b0001, 1'b0}) begin
          errors++;
          $display("FAIL b2b_adder_in cyc%0d: got %b want %b", cyc, adder_got,
                   {acc_exp, 4'b0001, 1'b0});
        end
        acc_exp = acc_exp + 4'b0001;
      end
      if (bus.out_valid === 1'b1) begin
        checks++;
        if (bus.acc !== acc_exp) begin
          errors++;
          $display("FAIL b2b_acc cyc%0d: got %b want %b", cyc, bus.acc, acc_exp);
        end
      end
      in_exec = (bus.in_ready === 1'b1) && bus.in_valid;
      if (in_exec) begin
        if (last >= 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL b2b_spacing: got %0d cycles want 3", cyc - last);
          end
        end
        last = cyc;
        n_acc++;
      end
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (n_acc != 4 || bus.acc !== 4'b0100) begin
      errors++;
      $display("FAIL b2b_final: accepts %0d acc %b want 4 0100", n_acc, bus.acc);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 2'b00;
    bus.operand   = 4'b0000;
    bus.out_ready = 1'b0;
    test_reset();
    test_addsub();
    test_wrap_clear();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
